// File: rtl/mfcc_pkg.sv
// Shared types and constants for the MFCC frame sequencer and its watchdog.
package mfcc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2
    } seq_state_e;

    localparam int MAX_COEFFS  = 31;
    localparam int WDOG_CYCLES = 4096;
    localparam int SAMPLE_W    = 16;
    localparam int COEF_W      = 32;
    localparam int WDOG_W      = 12;

    // A frame must hold at least two samples, advance by at least one, and yield 1..31 coefficients
    function automatic logic cfg_is_valid(input logic [7:0] size,
                                          input logic [7:0] ovl,
                                          input logic [7:0] ncoef);
        return (size >= 8'd2) && (ovl < size) &&
               (ncoef >= 8'd1) && (ncoef <= 8'(MAX_COEFFS));
    endfunction

endpackage

// File: rtl/mfcc_watchdog.sv
// Loadable down-counter; expire fires on a running cycle that finds the count at zero.
module mfcc_watchdog
    import mfcc_pkg::*;
#(
    parameter int W = WDOG_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         run,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: reload wins over counting down, and the count parks at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (run && (cnt_q != {W{1'b0}})) begin
            cnt_d = cnt_q - W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    assign expire = run && !load && (cnt_q == {W{1'b0}});

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mfcc_frame_sequencer.sv
// Streams audio into the MFCC accelerator one frame at a time and tags the returned
// coefficients with their index and frame number.
module mfcc_frame_sequencer
    import mfcc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic [7:0]  cfg_frame_size,
    input  logic [7:0]  cfg_frame_overlap,
    input  logic [7:0]  cfg_num_coeffs,
    input  logic [15:0] src_sample,
    input  logic        src_valid,
    output logic        src_ready,
    output logic [15:0] acc_audio,
    output logic        acc_valid,
    output logic [7:0]  acc_frame_size,
    output logic [7:0]  acc_frame_overlap,
    output logic [7:0]  acc_num_coeffs,
    input  logic [31:0] acc_mfcc,
    input  logic        acc_mfcc_valid,
    output logic [31:0] coef_out,
    output logic        coef_valid,
    output logic [4:0]  coef_idx,
    output logic [15:0] frame_idx,
    output logic        frame_done,
    output logic        busy,
    output logic        cfg_err,
    output logic        spurious,
    output logic        timeout,
    input  logic        err_clr
);

    seq_state_e            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [7:0]            need_q, need_d;
    logic [4:0]            coef_cnt_q, coef_cnt_d;
    logic [15:0]           frame_cnt_q, frame_cnt_d;
    logic                  stop_pend_q, stop_pend_d;
    logic [7:0]            size_q, size_d, ovl_q, ovl_d, ncoef_q, ncoef_d;
    logic                  src_ready_q, src_ready_d;
    logic [SAMPLE_W-1:0]   acc_audio_q, acc_audio_d;
    logic                  acc_valid_q, acc_valid_d;
    logic [COEF_W-1:0]     coef_out_q, coef_out_d;
    logic                  coef_valid_q, coef_valid_d;
    logic [4:0]            coef_idx_q, coef_idx_d;
    logic [15:0]           frame_idx_q, frame_idx_d;
    logic                  frame_done_q, frame_done_d;
    logic                  busy_q, busy_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  spurious_q, spurious_d;
    logic                  timeout_q, timeout_d;

    logic                  hs_s, last_hs_s, last_coef_s;
    logic                  cfg_err_set_s, spurious_set_s, timeout_set_s;
    logic                  wd_load_s, wd_run_s, wd_expire_s;
    logic [7:0]            hop_s;

    assign hs_s        = src_valid && src_ready_q;
    assign last_hs_s   = hs_s && ((cnt_q + 8'd1) == need_q);
    assign last_coef_s = ({3'd0, coef_cnt_q} == (ncoef_q - 8'd1));
    assign hop_s       = size_q - ovl_q;

    // The watchdog restarts on entry to DRAIN and on every coefficient, so it measures silent gaps
    assign wd_run_s  = (state_q == ST_DRAIN);
    assign wd_load_s = ((state_q == ST_STREAM) && last_hs_s) ||
                       ((state_q == ST_DRAIN) && acc_mfcc_valid);

    mfcc_watchdog #(.W(WDOG_W)) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (wd_load_s),
        .run      (wd_run_s),
        .load_val (12'(WDOG_CYCLES - 1)),
        .expire   (wd_expire_s)
    );

    // Sequencer next-state and registered-output computation
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        need_d         = need_q;
        coef_cnt_d     = coef_cnt_q;
        frame_cnt_d    = frame_cnt_q;
        size_d         = size_q;
        ovl_d          = ovl_q;
        ncoef_d        = ncoef_q;
        acc_audio_d    = acc_audio_q;
        acc_valid_d    = 1'b0;
        coef_out_d     = coef_out_q;
        coef_valid_d   = 1'b0;
        coef_idx_d     = coef_idx_q;
        frame_idx_d    = frame_idx_q;
        frame_done_d   = 1'b0;
        cfg_err_set_s  = 1'b0;
        timeout_set_s  = 1'b0;
        spurious_set_s = acc_mfcc_valid && (state_q != ST_DRAIN);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_is_valid(cfg_frame_size, cfg_frame_overlap, cfg_num_coeffs)) begin
                        size_d      = cfg_frame_size;
                        ovl_d       = cfg_frame_overlap;
                        ncoef_d     = cfg_num_coeffs;
                        need_d      = cfg_frame_size;
                        cnt_d       = 8'd0;
                        coef_cnt_d  = 5'd0;
                        frame_cnt_d = 16'd0;
                        frame_idx_d = 16'd0;
                        state_d     = ST_STREAM;
                    end else begin
                        cfg_err_set_s = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STREAM: begin
                if (hs_s) begin
                    acc_audio_d = src_sample;
                    acc_valid_d = 1'b1;
                    if (last_hs_s) begin
                        cnt_d      = 8'd0;
                        coef_cnt_d = 5'd0;
                        state_d    = ST_DRAIN;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (wd_expire_s) begin
                    timeout_set_s = 1'b1;
                    state_d       = ST_IDLE;
                end else if (acc_mfcc_valid) begin
                    coef_out_d   = acc_mfcc;
                    coef_valid_d = 1'b1;
                    coef_idx_d   = coef_cnt_q;
                    frame_idx_d  = frame_cnt_q;
                    if (last_coef_s) begin
                        frame_done_d = 1'b1;
                        frame_cnt_d  = frame_cnt_q + 16'd1;
                        coef_cnt_d   = 5'd0;
                        // A stop arriving on the final coefficient itself still ends the run here
                        if (stop_pend_q || stop) begin
                            state_d = ST_IDLE;
                        end else begin
                            need_d  = hop_s;
                            cnt_d   = 8'd0;
                            state_d = ST_STREAM;
                        end
                    end else begin
                        coef_cnt_d = coef_cnt_q + 5'd1;
                    end
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        src_ready_d = (state_d == ST_STREAM);
        busy_d      = (state_d != ST_IDLE);

        if (state_d == ST_IDLE) begin
            stop_pend_d = 1'b0;
        end else if ((state_q != ST_IDLE) && stop) begin
            stop_pend_d = 1'b1;
        end else begin
            stop_pend_d = stop_pend_q;
        end

        if (cfg_err_set_s) begin
            cfg_err_d = 1'b1;
        end else if (err_clr) begin
            cfg_err_d = 1'b0;
        end else begin
            cfg_err_d = cfg_err_q;
        end

        if (spurious_set_s) begin
            spurious_d = 1'b1;
        end else if (err_clr) begin
            spurious_d = 1'b0;
        end else begin
            spurious_d = spurious_q;
        end

        if (timeout_set_s) begin
            timeout_d = 1'b1;
        end else if (err_clr) begin
            timeout_d = 1'b0;
        end else begin
            timeout_d = timeout_q;
        end
    end

    // State, counters, latched configuration and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            need_q       <= 8'd0;
            coef_cnt_q   <= 5'd0;
            frame_cnt_q  <= 16'd0;
            stop_pend_q  <= 1'b0;
            size_q       <= 8'd0;
            ovl_q        <= 8'd0;
            ncoef_q      <= 8'd0;
            src_ready_q  <= 1'b0;
            acc_audio_q  <= 16'd0;
            acc_valid_q  <= 1'b0;
            coef_out_q   <= 32'd0;
            coef_valid_q <= 1'b0;
            coef_idx_q   <= 5'd0;
            frame_idx_q  <= 16'd0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            spurious_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            need_q       <= need_d;
            coef_cnt_q   <= coef_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            stop_pend_q  <= stop_pend_d;
            size_q       <= size_d;
            ovl_q        <= ovl_d;
            ncoef_q      <= ncoef_d;
            src_ready_q  <= src_ready_d;
            acc_audio_q  <= acc_audio_d;
            acc_valid_q  <= acc_valid_d;
            coef_out_q   <= coef_out_d;
            coef_valid_q <= coef_valid_d;
            coef_idx_q   <= coef_idx_d;
            frame_idx_q  <= frame_idx_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            cfg_err_q    <= cfg_err_d;
            spurious_q   <= spurious_d;
            timeout_q    <= timeout_d;
        end
    end

    assign src_ready         = src_ready_q;
    assign acc_audio         = acc_audio_q;
    assign acc_valid         = acc_valid_q;
    assign acc_frame_size    = size_q;
    assign acc_frame_overlap = ovl_q;
    assign acc_num_coeffs    = ncoef_q;
    assign coef_out          = coef_out_q;
    assign coef_valid        = coef_valid_q;
    assign coef_idx          = coef_idx_q;
    assign frame_idx         = frame_idx_q;
    assign frame_done        = frame_done_q;
    assign busy              = busy_q;
    assign cfg_err           = cfg_err_q;
    assign spurious          = spurious_q;
    assign timeout           = timeout_q;

endmodule
